os_drain_collector: RTL and testbench

- Receive end of the output-stationary result drain chain: sits below the last PE of one array column and captures the 2*D_W accumulator results that the column shifts out on its out_data/out_valid chain.
- Tags each beat with its row index and buffers it in a small FIFO. Presents beats downstream on a valid/ready stream, because the PE chain itself has no backpressure.
- One instance per column.

---
 rtl/os_pkg.sv | 24 ++
 rtl/os_sync_fifo.sv | 52 +++++
 rtl/os_drain_collector.sv | 122 ++++++++++++
 tb/tb_os_drain_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/os_pkg.sv
// Shared types for the output-stationary drain collector: default build widths,
// the tagged beat record and the collector FSM states.
package os_pkg;

    localparam int D_W_DFLT   = 8;
    localparam int N_DFLT     = 4;
    localparam int DEPTH_DFLT = 8;
    localparam int RES_W      = 2 * D_W_DFLT;
    localparam int ROW_W      = $clog2(N_DFLT);

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [ROW_W-1:0] row;
        logic             last;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_EMPTY,
        DONE
    } state_e;

endpackage

// File: rtl/os_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Read data comes straight from the storage array, so a push is visible one edge later.
module os_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO still takes a push when the same edge frees a slot.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; contents are only observed behind a non-empty flag.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/os_drain_collector.sv
// Bottom-of-column drain receiver: tags each result with its row, buffers it and
// re-presents it on a valid/ready stream since the PE chain cannot be stalled.
module os_drain_collector
    import os_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*D_W-1:0]     in_data,
    input  logic                 in_valid,
    output logic [2*D_W-1:0]     m_data,
    output logic [$clog2(N)-1:0] m_row,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err_ovf,
    output logic                 err_unexp,
    input  logic                 err_clr
);

    localparam int             RW       = 2 * D_W;
    localparam int             CW       = $clog2(N);
    localparam int             BW       = RW + CW + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic            r_err_ovf;
    logic            r_err_unexp;
    logic            w_beat;
    logic            w_last;
    logic [CW-1:0]   w_row;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_ovf;
    logic            w_unexp;
    logic [BW-1:0]   w_din;
    logic [BW-1:0]   w_dout;

    // The bottom row leaves the column first, so rows are tagged in descending order.
    assign w_beat  = (r_state == COLLECT) && in_valid;
    assign w_last  = (r_count == LAST_CNT);
    assign w_row   = LAST_CNT - r_count;
    assign w_din   = {in_data, w_row, w_last};
    assign w_pop   = m_ready && !w_empty;
    assign w_ovf   = w_beat && w_full && !w_pop;
    assign w_unexp = in_valid && (r_state != COLLECT);

    os_sync_fifo #(
        .WIDTH(BW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_beat),
        .pop  (w_pop),
        .din  (w_din),
        .dout (w_dout),
        .full (w_full),
        .empty(w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (start) w_state_nxt = COLLECT;
            COLLECT:    if (w_beat && w_last) w_state_nxt = WAIT_EMPTY;
            WAIT_EMPTY: if (w_empty) w_state_nxt = DONE;
            DONE:       w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // A dropped beat still advances the count so the drain always terminates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_count <= '0;
        end else if (w_beat) begin
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

    // Sticky flags: a new event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf   <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            if (w_ovf)        r_err_ovf <= 1'b1;
            else if (err_clr) r_err_ovf <= 1'b0;
            if (w_unexp)      r_err_unexp <= 1'b1;
            else if (err_clr) r_err_unexp <= 1'b0;
        end
    end

    always_comb begin
        m_valid                  = !w_empty;
        {m_data, m_row, m_last}  = m_valid ? w_dout : '0;
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err_ovf   = r_err_ovf;
    assign err_unexp = r_err_unexp;

endmodule

// File: tb/tb_os_drain_collector.sv
// Drives a standard-depth and a deliberately shallow collector with the same stimulus
// and compares both against a queue-based model of the drain rules.
module tb_os_drain_collector;
    import os_pkg::*;

    localparam int NR = 4;
    localparam int M_IDLE = 0, M_COLL = 1, M_WAIT = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic [15:0] m_data [2];
    logic [1:0]  m_row [2];
    logic        m_last [2];
    logic        m_valid [2];
    logic        busy [2];
    logic        done [2];
    logic        err_ovf [2];
    logic        err_unexp [2];

    int errors = 0;
    int checks = 0;

    beat_t mq [2][$];
    int    mode [2];
    int    seen [2];
    bit    e_ovf [2];
    bit    e_unx [2];

    always #5 clk = ~clk;

    os_drain_collector #(.D_W(8), .N(NR), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .m_data(m_data[0]), .m_row(m_row[0]), .m_last(m_last[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready), .busy(busy[0]), .done(done[0]), .err_ovf(err_ovf[0]),
        .err_unexp(err_unexp[0]), .err_clr(err_clr)
    );

    // Shallower than one drain, so overflow and push-while-full-with-pop are reachable.
    os_drain_collector #(.D_W(8), .N(NR), .DEPTH(2)) u_dut_small (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .m_data(m_data[1]), .m_row(m_row[1]), .m_last(m_last[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready), .busy(busy[1]), .done(done[1]), .err_ovf(err_ovf[1]),
        .err_unexp(err_unexp[1]), .err_clr(err_clr)
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mode[k]  = M_IDLE;
            seen[k]  = 0;
            e_ovf[k] = 1'b0;
            e_unx[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input int k);
        int    occ;
        int    nm;
        bit    pop;
        bit    ovf;
        bit    unx;
        beat_t b;
        occ = mq[k].size();
        pop = m_ready && (occ > 0);
        unx = in_valid && (mode[k] != M_COLL);
        ovf = 1'b0;
        nm  = mode[k];
        case (mode[k])
            M_IDLE: if (start) begin nm = M_COLL; seen[k] = 0; end
            M_WAIT: if (occ == 0) nm = M_DONE;
            M_DONE: nm = M_IDLE;
            default: ;
        endcase
        if (pop) void'(mq[k].pop_front());
        if (mode[k] == M_COLL && in_valid) begin
            b.data = in_data;
            b.row  = ROW_W'(NR - 1 - seen[k]);
            b.last = (seen[k] == NR - 1);
            if (occ < depth_of(k) || pop) mq[k].push_back(b);
            else ovf = 1'b1;
            seen[k]++;
            if (seen[k] == NR) nm = M_WAIT;
        end
        mode[k]  = nm;
        e_ovf[k] = ovf ? 1'b1 : (err_clr ? 1'b0 : e_ovf[k]);
        e_unx[k] = unx ? 1'b1 : (err_clr ? 1'b0 : e_unx[k]);
    endtask

    task automatic compare(input int k);
        bit exp_valid;
        exp_valid = (mq[k].size() > 0);
        check("m_valid", k, 32'(m_valid[k]), 32'(exp_valid));
        if (exp_valid) begin
            check("m_data", k, 32'(m_data[k]), 32'(mq[k][0].data));
            check("m_row",  k, 32'(m_row[k]),  32'(mq[k][0].row));
            check("m_last", k, 32'(m_last[k]), 32'(mq[k][0].last));
        end
        check("busy",      k, 32'(busy[k]),      32'(mode[k] != M_IDLE));
        check("done",      k, 32'(done[k]),      32'(mode[k] == M_DONE));
        check("err_ovf",   k, 32'(err_ovf[k]),   32'(e_ovf[k]));
        check("err_unexp", k, 32'(err_unexp[k]), 32'(e_unx[k]));
    endtask

    task automatic compare_zero();
        for (int k = 0; k < 2; k++) begin
            compare(k);
            check("rst_m_data", k, 32'(m_data[k]), 32'd0);
            check("rst_m_row",  k, 32'(m_row[k]),  32'd0);
            check("rst_m_last", k, 32'(m_last[k]), 32'd0);
        end
    endtask

    task automatic step(input bit st, input bit v, input logic [15:0] d, input bit r, input bit c);
        @(negedge clk);
        start = st; in_valid = v; in_data = d; m_ready = r; err_clr = c;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, r, 1'b0);
    endtask

    // Asserted between edges so the clear must act without waiting for clk.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_zero();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] pat [4];
        pat[0] = 16'h0A11; pat[1] = 16'h0B22; pat[2] = 16'h0C33; pat[3] = 16'h0D44;

        model_reset();
        #1;
        compare_zero();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // stray beat in IDLE, then clear
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // basic drain, always ready
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat[i], 1'b1, 1'b0);
        idle(4, 1'b1);

        // backpressure for 10 cycles, then drain (shallow instance overflows)
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat[i], 1'b0, 1'b0);
        idle(10, 1'b0);
        idle(8, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // full FIFO with simultaneous pop on the shallow instance
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h5501, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h5502, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h5503, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h5504, 1'b1, 1'b0);
        idle(5, 1'b1);

        // start during COLLECT must not restart the count
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h6601, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h6602, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h6603, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h6604, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h6605, 1'b1, 1'b0);
        idle(4, 1'b1);

        // set beats clear when both land together
        step(1'b0, 1'b1, 16'h7777, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // reset mid-drain, then a fresh drain
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h8801, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h8802, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat[i], 1'b1, 1'b0);
        idle(4, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1,
                 16'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
